// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed little-endian byte stream, assembles 32-bit words
// and writes them to program memory while holding the CPU in reset until the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte
// after the payload; without it the last write (or an empty load) goes straight to DONE.
module program_loader #(
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e FinalSt = StCheck;
`else
    localparam state_e FinalSt = StDone;
`endif

    localparam logic [16:0] DepthLim = 17'(MEMORY_DEPTH);

    state_e      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] word_q, word_d;
    logic [15:0] words_q, words_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        byte_ready_q, byte_ready_d;
    logic        mem_write_q, mem_write_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        accept;
    logic [15:0] len_rx;
    logic [16:0] words_inc;

    assign accept    = byte_valid_i & byte_ready_q;
    assign len_rx    = {byte_i, len_lo_q};
    assign words_inc = {1'b0, words_q} + 17'd1;

    // Next-state, datapath and registered-output decode; outputs follow the next state so they
    // line up exactly with the state register.
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        words_d    = words_q;
        addr_d     = addr_q;
        data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d    = StLenLo;
                    words_d    = 16'd0;
                    byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_lo_d = byte_i;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx == 16'd0) begin
                        state_d = FinalSt;
                    end else if ({1'b0, len_rx} > DepthLim) begin
                        state_d = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + byte_i;
`endif
                    // Counter wraps to zero after the fourth byte, ready for the next word.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = byte_i;
                        2'd1:    word_d[15:8]  = byte_i;
                        2'd2:    word_d[23:16] = byte_i;
                        default: begin
                            data_d  = {byte_i, word_q};
                            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                            state_d = StWrite;
                        end
                    endcase
                end
            end
            StWrite: begin
                words_d = words_inc[15:0];
                state_d = (words_inc < {1'b0, len_q}) ? StData : FinalSt;
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    state_d = (byte_i == sum_q) ? StDone : StError;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        byte_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                       (state_d == StData)  || (state_d == StCheck);
        mem_write_d  = (state_d == StWrite);
        cpu_reset_d  = (state_d != StDone);
        done_d       = (state_d == StDone);
        error_d      = (state_d == StError);
    end

    // State and output registers with synchronous reset; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            len_lo_q     <= 8'd0;
            len_q        <= 16'd0;
            byte_cnt_q   <= 2'd0;
            word_q       <= 24'd0;
            words_q      <= 16'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= byte_ready_d;
            mem_write_q  <= mem_write_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign byte_ready_o   = byte_ready_q;
    assign mem_write_o    = mem_write_q;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = data_q;
    assign cpu_reset_o    = cpu_reset_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 256, program memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first loaded word.
REQ-003 clk  input  1  the single clock of the block; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start_i  input  1  one-cycle pulse that begins a load session.
REQ-006 byte_i  input  8  incoming program byte.
REQ-007 byte_valid_i  input  1  byte_i holds a valid byte.
REQ-008 byte_ready_o  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid_i and byte_ready_o are both high at a rising edge.
REQ-009 mem_write_o  output  1  one-cycle program memory write strobe.
REQ-010 mem_addr_o  output  32  word-aligned byte address for the write.
REQ-011 mem_data_o  output  32  word to write.
REQ-012 cpu_reset_o  output  1  holds the MIPS processor in reset while high.
REQ-013 done_o  output  1  load completed successfully.
REQ-014 error_o  output  1  load aborted.
REQ-015 words_loaded_o  output  16  count of words written in the current session.

Function
REQ-016 States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR.
REQ-017 Stream format: 16-bit word count N (low byte first), then 4*N payload bytes, each word little-endian (first byte -> bits 7:0).
REQ-018 IDLE -> LEN_LO on start_i; start_i also clears words_loaded_o and error_o.
REQ-019 LEN_LO -> LEN_HI on accepted byte; LEN_HI -> DATA on accepted byte when 0 < N <= MEMORY_DEPTH.
REQ-020 N = 0 in LEN_HI: go to CHECK if the checksum feature is compiled in, else DONE; no writes.
REQ-021 N > MEMORY_DEPTH in LEN_HI: go to ERROR; no writes.
REQ-022 byte_ready_o high only in LEN_LO, LEN_HI, DATA, CHECK; low in all other states.
REQ-023 DATA: 4th accepted byte of a word moves to WRITE; in WRITE mem_write_o is high for exactly one cycle, mem_addr_o = BASE_ADDR + 4*words_loaded_o, mem_data_o = assembled word.
REQ-024 Latency: 4th byte accepted at edge k -> mem_write_o high in cycle after k; words_loaded_o increments on the edge ending WRITE.
REQ-025 WRITE -> DATA if words_loaded_o+1 < N; otherwise CHECK (checksum on) or DONE.
REQ-026 mem_write_o low in every state except WRITE; mem_addr_o/mem_data_o hold last values otherwise.
REQ-027 cpu_reset_o high in every state except DONE; done_o high only in DONE; error_o high only in ERROR.
REQ-028 start_i ignored in LEN_LO, LEN_HI, DATA, WRITE, CHECK; in DONE or ERROR it restarts at LEN_LO.
REQ-029 byte_valid_i low mid-word: loader waits indefinitely, partial word retained.

Reset
REQ-030 reset forces IDLE regardless of state, including mid-word or during WRITE (that write strobe is not issued).
REQ-031 Reset values: byte_ready_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0, cpu_reset_o 1, done_o 0, error_o 0, words_loaded_o 0.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN: when defined, CHECK state accepts one trailing byte equal to the mod-256 sum of all 4*N payload bytes; match -> DONE, mismatch -> ERROR.
REQ-033 Without LOADER_CHECKSUM_EN, CHECK state and the accumulator are absent; last WRITE (or N = 0) goes directly to DONE.

Verification
REQ-034 Reset, no start -> cpu_reset_o=1, done_o=0, byte_ready_o=0 indefinitely.
REQ-035 start, bytes 02 00 78 56 34 12 EF BE AD DE (checksum off) -> writes 0x12345678 @0x0, 0xDEADBEEF @0x4, done_o=1, cpu_reset_o=0, words_loaded_o=2.
REQ-036 Checksum on, N=1, payload 01 02 03 04, trailer 0A -> DONE; trailer 0B -> ERROR, error_o=1, cpu_reset_o=1.
REQ-037 N=257 with MEMORY_DEPTH=256 -> ERROR after 2nd byte, mem_write_o never asserted.
REQ-038 reset asserted after 3rd payload byte -> IDLE, no write strobe; fresh start reloads correctly from address BASE_ADDR.
REQ-039 byte_valid_i toggled randomly with gaps, start_i pulsed mid-load -> same writes as gap-free stream, start_i ignored.
